multicycle_control: RTL and testbench

Control FSM for the multi-cycle RV32I datapath. It sits on the driving side of the ALU: it decodes the held instruction register and sequences `ALUctrl`, the operand-mux selects, the result mux and all architectural write enables. It consumes the ALU `Zero` flag for branches and a `mem_ready` handshake from the shared instruction/data memory.

---
 rtl/control_pkg.sv | 43 ++++
 rtl/multicycle_control_if.sv | 29 ++
 rtl/alu_decoder.sv | 36 +++
 rtl/multicycle_control.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, ALU ops,
// mux selects and the opcodes it recognises.
package control_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2 = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;
   localparam logic [1:0] SRCB_4   = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_READ   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle. master = control FSM side, slave = datapath side.
interface multicycle_control_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] instr;
   logic             Zero;
   logic             mem_ready;
   logic [3:0]       ALUctrl;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ResultSrc;
   logic [2:0]       ImmSrc;
   logic             AdrSrc;
   logic             PCWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic             MemWrite;
   logic             illegal;

   modport master (
      input  instr, Zero, mem_ready,
      output ALUctrl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
             PCWrite, IRWrite, RegWrite, MemWrite, illegal
   );

   modport slave (
      output instr, Zero, mem_ready,
      input  ALUctrl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
             PCWrite, IRWrite, RegWrite, MemWrite, illegal
   );
endinterface

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] of R-type and I-ALU instructions to an ALU op and
// flags funct combinations this core does not implement.
module alu_decoder
   import control_pkg::*;
(
   input  logic       is_rtype,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_op,
   output logic       funct_illegal
);

   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         3'b000:  alu_op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_op = ALU_AND;
         3'b110:  alu_op = ALU_OR;
         3'b100:  alu_op = ALU_XOR;
         3'b010:  alu_op = ALU_SLT;
         3'b001:  alu_op = ALU_SLL;
         3'b101:  alu_op = ALU_SRL;
         default: alu_op = ALU_ADD;
      endcase
   end

   // For I-ALU, bit 30 is immediate data except on shifts, where it selects srai.
   always_comb begin
      funct_illegal = (funct3 == 3'b011);
      if (funct7_5) begin
         if (is_rtype) funct_illegal = funct_illegal || (funct3 != 3'b000);
         else          funct_illegal = funct_illegal || (funct3[1:0] == 2'b01);
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: decodes the held instruction and sequences
// ALU ops, operand/result muxes and architectural write enables.
module multicycle_control
   import control_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master bus
);

   state_t state_q, state_d;

   logic [WIDTH-1:0] ir;
   logic [6:0]       opcode, funct7;
   logic [2:0]       funct3;
   logic             is_ld, is_st, is_r, is_i, is_br, is_jal;
   logic [3:0]       dec_op;
   logic             dec_ill, f7_bad, legal;
   logic             unused_bits;

   assign ir          = bus.instr;
   assign opcode      = ir[6:0];
   assign funct3      = ir[14:12];
   assign funct7      = ir[31:25];
   assign unused_bits = ^{ir[24:15], ir[11:7]};

   assign is_ld  = (opcode == OP_LOAD);
   assign is_st  = (opcode == OP_STORE);
   assign is_r   = (opcode == OP_RTYPE);
   assign is_i   = (opcode == OP_IALU);
   assign is_br  = (opcode == OP_BRANCH);
   assign is_jal = (opcode == OP_JAL);

   alu_decoder u_alu_dec (
      .is_rtype      (is_r),
      .funct3        (funct3),
      .funct7_5      (funct7[5]),
      .alu_op        (dec_op),
      .funct_illegal (dec_ill)
   );

   // Only funct7 = 0000000 / 0100000 exist on R-type and immediate shifts.
   assign f7_bad = (is_r || (is_i && funct3[1:0] == 2'b01)) &&
                   (funct7[6] || funct7[4:0] != 5'b0);
   assign legal  = is_ld || is_st || is_jal ||
                   (is_br && funct3[2:1] == 2'b00) ||
                   ((is_r || is_i) && !dec_ill && !f7_bad);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   logic [3:0] alu_ctrl;
   logic [1:0] src_a, src_b, res_src;
   logic       adr_src, pc_we, ir_we, reg_we, mem_we, ill;

   always_comb begin
      state_d  = state_q;
      alu_ctrl = ALU_ADD;
      src_a    = SRCA_PC;
      src_b    = SRCB_RD2;
      res_src  = RES_ALUOUT;
      adr_src  = 1'b0;
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      reg_we   = 1'b0;
      mem_we   = 1'b0;
      ill      = 1'b0;
      case (state_q)
         S_FETCH: begin
            src_b   = SRCB_4;
            res_src = RES_ALURES;
            pc_we   = bus.mem_ready;
            ir_we   = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            src_a = SRCA_OLDPC;
            src_b = SRCB_IMM;
            if (!legal) begin
               ill     = 1'b1;
               state_d = S_FETCH;
            end
            else if (is_ld || is_st) state_d = S_MEMADR;
            else if (is_r)           state_d = S_EXECUTER;
            else if (is_i)           state_d = S_EXECUTEI;
            else if (is_br)          state_d = S_BRANCH;
            else                     state_d = S_JAL;
         end
         S_MEMADR: begin
            src_a   = SRCA_RD1;
            src_b   = SRCB_IMM;
            state_d = is_ld ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            res_src = RES_READ;
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            mem_we  = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            src_a    = SRCA_RD1;
            alu_ctrl = dec_op;
            state_d  = S_ALUWB;
         end
         S_EXECUTEI: begin
            src_a    = SRCA_RD1;
            src_b    = SRCB_IMM;
            alu_ctrl = dec_op;
            state_d  = S_ALUWB;
         end
         S_ALUWB: begin
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            src_a    = SRCA_RD1;
            alu_ctrl = ALU_SUB;
            pc_we    = bus.Zero ^ funct3[0];
            state_d  = S_FETCH;
         end
         S_JAL: begin
            src_a   = SRCA_OLDPC;
            src_b   = SRCB_4;
            pc_we   = 1'b1;
            state_d = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
      // Reset aborts any instruction in flight without committing a write.
      if (rst) begin
         pc_we   = 1'b0;
         ir_we   = 1'b0;
         reg_we  = 1'b0;
         mem_we  = 1'b0;
         ill     = 1'b0;
         state_d = S_FETCH;
      end
   end

   always_comb begin
      bus.ImmSrc = IMM_I;
      if (is_st)       bus.ImmSrc = IMM_S;
      else if (is_br)  bus.ImmSrc = IMM_B;
      else if (is_jal) bus.ImmSrc = IMM_J;
   end

   assign bus.ALUctrl   = alu_ctrl;
   assign bus.ALUSrcA   = src_a;
   assign bus.ALUSrcB   = src_b;
   assign bus.ResultSrc = res_src;
   assign bus.AdrSrc    = adr_src;
   assign bus.PCWrite   = pc_we;
   assign bus.IRWrite   = ir_we;
   assign bus.RegWrite  = reg_we;
   assign bus.MemWrite  = mem_we;
   assign bus.illegal   = ill;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors per instruction.
module tb_multicycle_control;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   multicycle_control_if #(.WIDTH(32)) bus ();

   multicycle_control #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {ALUctrl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, illegal}
   logic [15:0] obs;
   assign obs = {bus.ALUctrl, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                 bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.illegal};

   localparam logic [15:0] E_FETCH   = {4'b0000, 2'b00, 2'b10, 2'b10, 1'b0, 5'b11000};
   localparam logic [15:0] E_FWAIT   = {4'b0000, 2'b00, 2'b10, 2'b10, 1'b0, 5'b00000};
   localparam logic [15:0] E_DECODE  = {4'b0000, 2'b01, 2'b01, 2'b00, 1'b0, 5'b00000};
   localparam logic [15:0] E_DEC_ILL = {4'b0000, 2'b01, 2'b01, 2'b00, 1'b0, 5'b00001};
   localparam logic [15:0] E_MEMADR  = {4'b0000, 2'b10, 2'b01, 2'b00, 1'b0, 5'b00000};
   localparam logic [15:0] E_MEMREAD = {4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 5'b00000};
   localparam logic [15:0] E_MEMWB   = {4'b0000, 2'b00, 2'b00, 2'b01, 1'b0, 5'b00100};
   localparam logic [15:0] E_MEMWR   = {4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 5'b00010};
   localparam logic [15:0] E_ALUWB   = {4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00100};
   localparam logic [15:0] E_BR_T    = {4'b0001, 2'b10, 2'b00, 2'b00, 1'b0, 5'b10000};
   localparam logic [15:0] E_BR_N    = {4'b0001, 2'b10, 2'b00, 2'b00, 1'b0, 5'b00000};
   localparam logic [15:0] E_JAL     = {4'b0000, 2'b01, 2'b10, 2'b00, 1'b0, 5'b10000};

   function automatic logic [15:0] e_exr(input logic [3:0] op);
      return {op, 2'b10, 2'b00, 2'b00, 1'b0, 5'b00000};
   endfunction

   function automatic logic [15:0] e_exi(input logic [3:0] op);
      return {op, 2'b10, 2'b01, 2'b00, 1'b0, 5'b00000};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      bus.Zero = 1'b0;
      bus.instr = 32'h0000_0013;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (obs[4:0] !== 5'b0) begin
            failures++;
            $display("FAIL reset_enables cyc%0d got=%b want=00000", c, obs[4:0]);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic [15:0] ev [4];
      ev = '{E_FETCH, E_DECODE, e_exr(4'b0000), E_ALUWB};
      bus.instr = 32'h0020_81B3;
      for (int c = 0; c < 4; c++) begin
         bus.mem_ready = 1'b1; #1;
         checks++;
         if (obs !== ev[c]) begin
            failures++;
            $display("FAIL add cyc%0d got=%h want=%h", c, obs, ev[c]);
         end
         tick();
      end
   endtask

   task automatic test_fetch_wait();
      logic [15:0] ev [7];
      logic        mr [7];
      ev = '{E_FWAIT, E_FWAIT, E_FETCH, E_DECODE, e_exr(4'b0001), E_ALUWB, E_FWAIT};
      mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bus.instr = 32'h4020_81B3;
      for (int c = 0; c < 7; c++) begin
         bus.mem_ready = mr[c]; #1;
         checks++;
         if (obs !== ev[c]) begin
            failures++;
            $display("FAIL sub_fetchwait cyc%0d got=%h want=%h", c, obs, ev[c]);
         end
         tick();
      end
   endtask

   task automatic test_lw();
      logic [15:0] ev [8];
      logic        mr [8];
      ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB, E_FWAIT};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      bus.instr = 32'h0000_A283;
      #1;
      checks++;
      if (bus.ImmSrc !== 3'b000) begin
         failures++;
         $display("FAIL lw_immsrc got=%b want=000", bus.ImmSrc);
      end
      for (int c = 0; c < 8; c++) begin
         bus.mem_ready = mr[c]; #1;
         checks++;
         if (obs !== ev[c]) begin
            failures++;
            $display("FAIL lw cyc%0d got=%h want=%h", c, obs, ev[c]);
         end
         tick();
      end
   endtask

   task automatic test_sw();
      logic [15:0] ev [8];
      logic        mr [8];
      ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR, E_FWAIT};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      bus.instr = 32'h0050_A023;
      #1;
      checks++;
      if (bus.ImmSrc !== 3'b001) begin
         failures++;
         $display("FAIL sw_immsrc got=%b want=001", bus.ImmSrc);
      end
      for (int c = 0; c < 8; c++) begin
         bus.mem_ready = mr[c]; #1;
         checks++;
         if (obs !== ev[c]) begin
            failures++;
            $display("FAIL sw cyc%0d got=%h want=%h", c, obs, ev[c]);
         end
         tick();
      end
   endtask

   task automatic test_branch();
      logic [31:0] ins [3];
      logic        zr  [3];
      logic [15:0] br  [3];
      logic [15:0] ev  [4];
      ins = '{32'h0020_8063, 32'h0020_9063, 32'h0020_9063};
      zr  = '{1'b1, 1'b1, 1'b0};
      br  = '{E_BR_T, E_BR_N, E_BR_T};
      for (int t = 0; t < 3; t++) begin
         ev = '{E_FETCH, E_DECODE, br[t], E_FWAIT};
         bus.instr = ins[t];
         bus.Zero  = zr[t];
         #1;
         checks++;
         if (bus.ImmSrc !== 3'b010) begin
            failures++;
            $display("FAIL br_immsrc t%0d got=%b want=010", t, bus.ImmSrc);
         end
         for (int c = 0; c < 4; c++) begin
            bus.mem_ready = (c != 3); #1;
            checks++;
            if (obs !== ev[c]) begin
               failures++;
               $display("FAIL branch t%0d cyc%0d got=%h want=%h", t, c, obs, ev[c]);
            end
            tick();
         end
      end
      bus.Zero = 1'b0;
   endtask

   task automatic test_jal();
      logic [15:0] ev [5];
      ev = '{E_FETCH, E_DECODE, E_JAL, E_ALUWB, E_FWAIT};
      bus.instr = 32'h0000_00EF;
      #1;
      checks++;
      if (bus.ImmSrc !== 3'b011) begin
         failures++;
         $display("FAIL jal_immsrc got=%b want=011", bus.ImmSrc);
      end
      for (int c = 0; c < 5; c++) begin
         bus.mem_ready = (c != 4); #1;
         checks++;
         if (obs !== ev[c]) begin
            failures++;
            $display("FAIL jal cyc%0d got=%h want=%h", c, obs, ev[c]);
         end
         tick();
      end
   endtask

   task automatic test_itype();
      logic [31:0] ins [3];
      logic [3:0]  op  [3];
      logic [15:0] ev  [5];
      // andi, addi with imm bit 30 set (still ADD), slli
      ins = '{32'h0050_F193, 32'h4000_8193, 32'h0020_9193};
      op  = '{4'b0010, 4'b0000, 4'b0110};
      for (int t = 0; t < 3; t++) begin
         ev = '{E_FETCH, E_DECODE, e_exi(op[t]), E_ALUWB, E_FWAIT};
         bus.instr = ins[t];
         for (int c = 0; c < 5; c++) begin
            bus.mem_ready = (c != 4); #1;
            checks++;
            if (obs !== ev[c]) begin
               failures++;
               $display("FAIL itype t%0d cyc%0d got=%h want=%h", t, c, obs, ev[c]);
            end
            tick();
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] ins [5];
      logic [15:0] ev  [3];
      // sra, srai, sltu, funct7=0000001, lui
      ins = '{32'h4020_D1B3, 32'h4020_D193, 32'h0020_B1B3, 32'h0220_81B3, 32'h0000_0037};
      ev  = '{E_FETCH, E_DEC_ILL, E_FWAIT};
      for (int t = 0; t < 5; t++) begin
         bus.instr = ins[t];
         for (int c = 0; c < 3; c++) begin
            bus.mem_ready = (c != 2); #1;
            checks++;
            if (obs !== ev[c]) begin
               failures++;
               $display("FAIL illegal t%0d cyc%0d got=%h want=%h", t, c, obs, ev[c]);
            end
            tick();
         end
      end
   endtask

   task automatic test_reset_mid_store();
      logic [15:0] ev [4];
      logic        mr [4];
      ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0};
      bus.instr = 32'h0050_A023;
      for (int c = 0; c < 4; c++) begin
         bus.mem_ready = mr[c]; #1;
         checks++;
         if (obs !== ev[c]) begin
            failures++;
            $display("FAIL rstmid_pre cyc%0d got=%h want=%h", c, obs, ev[c]);
         end
         tick();
      end
      rst = 1'b1;
      bus.mem_ready = 1'b0; #1;
      checks++;
      if (obs[4:0] !== 5'b0) begin
         failures++;
         $display("FAIL rstmid_enables got=%b want=00000", obs[4:0]);
      end
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b1; #1;
      checks++;
      if (obs !== E_FETCH) begin
         failures++;
         $display("FAIL rstmid_fetch got=%h want=%h", obs, E_FETCH);
      end
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.instr     = 32'h0;
      bus.Zero      = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      test_reset();
      test_add();
      test_fetch_wait();
      test_lw();
      test_sw();
      test_branch();
      test_jal();
      test_itype();
      test_illegal();
      test_reset_mid_store();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
